// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared constants for the shift-add multiplier datapath and controller
package shift_add_pkg;

    localparam int DEF_M  = 8;
    localparam int DEF_N  = 8;
    localparam int CNT_W  = $clog2(DEF_N + 1);
    localparam int PROD_W = DEF_M + DEF_N;

    // One-hot command encoding shared with the controller
    localparam logic [3:0] CMD_LOAD  = 4'b0001;
    localparam logic [3:0] CMD_ADD   = 4'b0010;
    localparam logic [3:0] CMD_SHIFT = 4'b0100;
    localparam logic [3:0] CMD_OUT   = 4'b1000;

endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - multiplicand/accumulator/carry/multiplier registers with product publish
module shift_add_datapath
    import shift_add_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           load_cmd,
    input  logic           add_cmd,
    input  logic           shift_cmd,
    input  logic           out_cmd,
    output logic           lsb,
    output logic [M+N-1:0] product,
    output logic           product_valid,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = M + N;

    logic [M-1:0]  mreg_q, mreg_d;
    logic [M-1:0]  acc_q, acc_d;
    logic          c_q, c_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_d_q, out_d_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] product_q, product_d;
    logic          product_valid_q, product_valid_d;

    logic          active;
    logic          add_en;
    logic          shift_en;
    logic          publish;
    logic [M:0]    sum;
    logic [N:0]    q_ext;
    logic [N-1:0]  q_shift;

    always_comb begin
        active   = (cnt_q < CW'(N));
        add_en   = add_cmd && active;
        shift_en = shift_cmd && active;
        // Post-add value; shift consumes it so add+shift in one cycle behaves as add-then-shift
        sum      = add_en ? ({1'b0, acc_q} + {1'b0, mreg_q}) : {c_q, acc_q};
        q_ext    = {sum[0], q_q};
        q_shift  = N'(q_ext >> 1);
        publish  = out_cmd && !out_d_q;

        mreg_d          = mreg_q;
        acc_d           = acc_q;
        c_d             = c_q;
        q_d             = q_q;
        cnt_d           = cnt_q;
        busy_d          = busy_q;
        out_d_d         = out_cmd;
        product_d       = publish ? {acc_q, q_q} : product_q;
        product_valid_d = publish;

        if (load_cmd) begin
            mreg_d = multiplicand;
            q_d    = multiplier;
            acc_d  = '0;
            c_d    = 1'b0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (shift_en) begin
            acc_d = sum[M:1];
            q_d   = q_shift;
            c_d   = 1'b0;
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(N)) begin
                busy_d = 1'b0;
            end
        end else if (add_en) begin
            {c_d, acc_d} = sum;
        end

        if (load_cmd) begin
            lsb = multiplier[0];
        end else if (shift_en) begin
            lsb = q_shift[0];
        end else begin
            lsb = q_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mreg_q          <= '0;
            acc_q           <= '0;
            c_q             <= 1'b0;
            q_q             <= '0;
            cnt_q           <= '0;
            out_d_q         <= 1'b0;
            busy_q          <= 1'b0;
            product_q       <= '0;
            product_valid_q <= 1'b0;
        end else begin
            mreg_q          <= mreg_d;
            acc_q           <= acc_d;
            c_q             <= c_d;
            q_q             <= q_d;
            cnt_q           <= cnt_d;
            out_d_q         <= out_d_d;
            busy_q          <= busy_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
        end
    end

    assign product       = product_q;
    assign product_valid = product_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_shift_add_datapath.sv
// tb/tb_shift_add_datapath.sv - directed vector bench for shift_add_datapath
module tb_shift_add_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        load_cmd;
    logic        add_cmd;
    logic        shift_cmd;
    logic        out_cmd;
    logic        lsb;
    logic [15:0] product;
    logic        product_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_add_datapath #(.M(8), .N(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .load_cmd      (load_cmd),
        .add_cmd       (add_cmd),
        .shift_cmd     (shift_cmd),
        .out_cmd       (out_cmd),
        .lsb           (lsb),
        .product       (product),
        .product_valid (product_valid),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        logic        sep;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        load_cmd  = 1'b0;
        add_cmd   = 1'b0;
        shift_cmd = 1'b0;
        out_cmd   = 1'b0;
    endtask

    task automatic load_op(input logic [7:0] mc, input logic [7:0] mp);
        @(negedge clk);
        idle();
        multiplicand = mc;
        multiplier   = mp;
        load_cmd     = 1'b1;
        #1 check("lsb_on_load", 32'(lsb), 32'(mp[0]));
    endtask

    // Step i of the controller loop; sep splits add and shift into separate cycles
    task automatic step(input logic [7:0] mp, input int i, input logic sep);
        @(negedge clk);
        idle();
        if (mp[i] && sep) begin
            add_cmd = 1'b1;
            #1 check("lsb_during_add", 32'(lsb), 32'(mp[i]));
            @(negedge clk);
            idle();
        end
        shift_cmd = 1'b1;
        add_cmd   = mp[i] && !sep;
        if (i < 7) begin
            #1 check("lsb_on_shift", 32'(lsb), 32'(mp[i+1]));
        end
    endtask

    task automatic publish(input logic [15:0] exp);
        @(negedge clk);
        idle();
        out_cmd = 1'b1;
        @(negedge clk);
        out_cmd = 1'b0;
        check("product_valid_pulse", 32'(product_valid), 32'd1);
        check("product", 32'(product), 32'(exp));
        @(negedge clk);
        check("product_valid_low", 32'(product_valid), 32'd0);
        check("product_hold", 32'(product), 32'(exp));
    endtask

    task automatic run_mult(input logic [7:0] mc, input logic [7:0] mp, input logic sep,
                            input logic [15:0] exp);
        load_op(mc, mp);
        for (int i = 0; i < 8; i++) begin
            step(mp, i, sep);
            if (i == 0) check("busy_after_load", 32'(busy), 32'd1);
            if (i == 7) check("busy_before_last", 32'(busy), 32'd1);
        end
        @(negedge clk);
        idle();
        check("busy_done", 32'(busy), 32'd0);
        publish(exp);
    endtask

    initial begin
        vecs[0] = '{mc: 8'd13,  mp: 8'd11,  sep: 1'b1, prod: 16'd143};
        vecs[1] = '{mc: 8'd255, mp: 8'd255, sep: 1'b0, prod: 16'hFE01};
        vecs[2] = '{mc: 8'd0,   mp: 8'd200, sep: 1'b0, prod: 16'd0};
        vecs[3] = '{mc: 8'd200, mp: 8'd0,   sep: 1'b1, prod: 16'd0};
        vecs[4] = '{mc: 8'd5,   mp: 8'h05,  sep: 1'b0, prod: 16'd25};
        vecs[5] = '{mc: 8'd255, mp: 8'd255, sep: 1'b1, prod: 16'hFE01};
        vecs[6] = '{mc: 8'd1,   mp: 8'd255, sep: 1'b0, prod: 16'd255};
        vecs[7] = '{mc: 8'd7,   mp: 8'd6,   sep: 1'b1, prod: 16'd42};

        rst          = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_product", 32'(product), 32'd0);
        check("reset_valid", 32'(product_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_lsb", 32'(lsb), 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_mult(vecs[v].mc, vecs[v].mp, vecs[v].sep, vecs[v].prod);
        end

        // Commands after the last shift must leave the result frozen
        run_mult(8'd13, 8'd11, 1'b1, 16'd143);
        @(negedge clk); idle(); shift_cmd = 1'b1;
        @(negedge clk); idle(); add_cmd = 1'b1;
        @(negedge clk); idle(); add_cmd = 1'b1; shift_cmd = 1'b1;
        @(negedge clk); idle();
        check("busy_after_extra", 32'(busy), 32'd0);
        publish(16'd143);

        // Reset mid-multiply, coincident with a load: reset wins
        load_op(8'd13, 8'd11);
        for (int i = 0; i < 3; i++) step(8'd11, i, 1'b0);
        @(negedge clk);
        idle();
        rst          = 1'b1;
        load_cmd     = 1'b1;
        multiplier   = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("rst_product", 32'(product), 32'd0);
        check("rst_valid", 32'(product_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lsb", 32'(lsb), 32'd0);

        run_mult(8'd7, 8'd6, 1'b0, 16'd42);

        // Level-high out_cmd publishes once
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            idle();
            out_cmd = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (product_valid) pulses++;
            end
            out_cmd = 1'b0;
            @(negedge clk);
            if (product_valid) pulses++;
            check("level_out_pulses", 32'(pulses), 32'd1);
            check("level_out_product", 32'(product), 32'd42);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
